// File: rtl/idct_block_loader.sv
// Zigzag-to-raster coefficient loader for a 64-input IDCT: clamps each coefficient,
// zero-fills after EOB and presents whole blocks on 64 parallel words with valid/ready.
module idct_block_loader #(
   parameter int WIDTH      = 16,
   parameter int CLAMP_BITS = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_valid,
   input  logic                    in_eob,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
   output logic signed [WIDTH-1:0] out8,  out9,  out10, out11, out12, out13, out14, out15,
   output logic signed [WIDTH-1:0] out16, out17, out18, out19, out20, out21, out22, out23,
   output logic signed [WIDTH-1:0] out24, out25, out26, out27, out28, out29, out30, out31,
   output logic signed [WIDTH-1:0] out32, out33, out34, out35, out36, out37, out38, out39,
   output logic signed [WIDTH-1:0] out40, out41, out42, out43, out44, out45, out46, out47,
   output logic signed [WIDTH-1:0] out48, out49, out50, out51, out52, out53, out54, out55,
   output logic signed [WIDTH-1:0] out56, out57, out58, out59, out60, out61, out62, out63,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag
);

   localparam logic signed [WIDTH-1:0] C_MAX = WIDTH'((1 << (CLAMP_BITS - 1)) - 1);
   localparam logic signed [WIDTH-1:0] C_MIN = ~C_MAX;

   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   typedef enum logic {S_FILL, S_FULL} state_t;

   function automatic logic is_sat(input logic signed [WIDTH-1:0] v);
      return (v > C_MAX) || (v < C_MIN);
   endfunction

   function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] v);
      if (v > C_MAX)      return C_MAX;
      else if (v < C_MIN) return C_MIN;
      else                return v;
   endfunction

   state_t                  r_state, w_state_nxt;
   logic [5:0]              r_idx;
   logic signed [WIDTH-1:0] r_fill [64];
   logic                    r_fill_sat;
   logic signed [WIDTH-1:0] r_out [64];
   logic                    r_out_valid;
   logic                    r_sat_out;
   logic                    w_accept;
   logic                    w_xfer;

   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_out_valid;
   assign sat_flag  = r_sat_out;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FILL;
      else     r_state <= w_state_nxt;
   end

   // in_ready is a function of state and rst only, never of in_valid
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_xfer      = 1'b0;
      case (r_state)
         S_FILL: begin
            in_ready = !rst;
            if (in_valid && !rst && (r_idx == 6'd63 || in_eob))
               w_state_nxt = S_FULL;
         end
         S_FULL: begin
            if (!r_out_valid || out_ready) begin
               w_xfer      = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
      endcase
   end

   // Clearing the fill bank on every transfer is what realises EOB zero-fill
   always_ff @(posedge clk) begin
      if (rst || w_xfer) begin
         for (int i = 0; i < 64; i++) r_fill[i] <= '0;
         r_fill_sat <= 1'b0;
         r_idx      <= '0;
      end else if (w_accept) begin
         r_fill[ZZ[r_idx]] <= clamp(in_data);
         r_fill_sat        <= r_fill_sat | is_sat(in_data);
         r_idx             <= r_idx + 6'd1;
      end
   end

   // A transfer on the same edge as downstream acceptance keeps out_valid high
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) r_out[i] <= '0;
         r_out_valid <= 1'b0;
         r_sat_out   <= 1'b0;
      end else if (w_xfer) begin
         r_out       <= r_fill;
         r_out_valid <= 1'b1;
         r_sat_out   <= r_fill_sat;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out0  = r_out[0];  assign out1  = r_out[1];  assign out2  = r_out[2];  assign out3  = r_out[3];
   assign out4  = r_out[4];  assign out5  = r_out[5];  assign out6  = r_out[6];  assign out7  = r_out[7];
   assign out8  = r_out[8];  assign out9  = r_out[9];  assign out10 = r_out[10]; assign out11 = r_out[11];
   assign out12 = r_out[12]; assign out13 = r_out[13]; assign out14 = r_out[14]; assign out15 = r_out[15];
   assign out16 = r_out[16]; assign out17 = r_out[17]; assign out18 = r_out[18]; assign out19 = r_out[19];
   assign out20 = r_out[20]; assign out21 = r_out[21]; assign out22 = r_out[22]; assign out23 = r_out[23];
   assign out24 = r_out[24]; assign out25 = r_out[25]; assign out26 = r_out[26]; assign out27 = r_out[27];
   assign out28 = r_out[28]; assign out29 = r_out[29]; assign out30 = r_out[30]; assign out31 = r_out[31];
   assign out32 = r_out[32]; assign out33 = r_out[33]; assign out34 = r_out[34]; assign out35 = r_out[35];
   assign out36 = r_out[36]; assign out37 = r_out[37]; assign out38 = r_out[38]; assign out39 = r_out[39];
   assign out40 = r_out[40]; assign out41 = r_out[41]; assign out42 = r_out[42]; assign out43 = r_out[43];
   assign out44 = r_out[44]; assign out45 = r_out[45]; assign out46 = r_out[46]; assign out47 = r_out[47];
   assign out48 = r_out[48]; assign out49 = r_out[49]; assign out50 = r_out[50]; assign out51 = r_out[51];
   assign out52 = r_out[52]; assign out53 = r_out[53]; assign out54 = r_out[54]; assign out55 = r_out[55];
   assign out56 = r_out[56]; assign out57 = r_out[57]; assign out58 = r_out[58]; assign out59 = r_out[59];
   assign out60 = r_out[60]; assign out61 = r_out[61]; assign out62 = r_out[62]; assign out63 = r_out[63];

endmodule

// File: tb/tb_idct_block_loader.sv
// Directed-plus-random bench for idct_block_loader; expected blocks come from a
// zigzag walk of the 8x8 grid and plain-integer clamping.
module tb_idct_block_loader;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_eob;
   logic               in_ready;
   logic signed [15:0] o [64];
   logic               out_valid;
   logic               out_ready;
   logic               sat_flag;

   int                 n_vec = 0;
   int                 n_err = 0;
   int                 zz [64];
   logic signed [15:0] stim [64];
   logic signed [15:0] exp_o [64];
   logic               exp_sat;
   logic signed [15:0] hold_o [64];
   logic               hold_sat;

   always #5 clk = ~clk;

   idct_block_loader #(.WIDTH(16), .CLAMP_BITS(12)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_eob(in_eob), .in_ready(in_ready),
      .out0(o[0]),   .out1(o[1]),   .out2(o[2]),   .out3(o[3]),   .out4(o[4]),   .out5(o[5]),   .out6(o[6]),   .out7(o[7]),
      .out8(o[8]),   .out9(o[9]),   .out10(o[10]), .out11(o[11]), .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
      .out16(o[16]), .out17(o[17]), .out18(o[18]), .out19(o[19]), .out20(o[20]), .out21(o[21]), .out22(o[22]), .out23(o[23]),
      .out24(o[24]), .out25(o[25]), .out26(o[26]), .out27(o[27]), .out28(o[28]), .out29(o[29]), .out30(o[30]), .out31(o[31]),
      .out32(o[32]), .out33(o[33]), .out34(o[34]), .out35(o[35]), .out36(o[36]), .out37(o[37]), .out38(o[38]), .out39(o[39]),
      .out40(o[40]), .out41(o[41]), .out42(o[42]), .out43(o[43]), .out44(o[44]), .out45(o[45]), .out46(o[46]), .out47(o[47]),
      .out48(o[48]), .out49(o[49]), .out50(o[50]), .out51(o[51]), .out52(o[52]), .out53(o[53]), .out54(o[54]), .out55(o[55]),
      .out56(o[56]), .out57(o[57]), .out58(o[58]), .out59(o[59]), .out60(o[60]), .out61(o[61]), .out62(o[62]), .out63(o[63]),
      .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Zigzag order: walk anti-diagonals, alternating direction
   task automatic build_zz;
      int k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
         else            for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
   endtask

   task automatic model(input int n);
      exp_sat = 1'b0;
      for (int i = 0; i < 64; i++) exp_o[i] = '0;
      for (int k = 0; k < n; k++) begin
         int c = stim[k];
         if (c > 2047)       begin c = 2047;  exp_sat = 1'b1; end
         else if (c < -2048) begin c = -2048; exp_sat = 1'b1; end
         exp_o[zz[k]] = 16'(c);
      end
   endtask

   task automatic check_out(input string tag, input logic signed [15:0] e [64], input logic es);
      for (int i = 0; i < 64; i++) chk(tag, 32'(o[i]), 32'(e[i]));
      chk({tag, "_sat"}, 32'(sat_flag), 32'(es));
   endtask

   task automatic send_block(input int n, input bit eob, input int gap_pct);
      for (int k = 0; k < n; k++) begin
         int g = 0;
         while (g < 16 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0; in_data = 16'($urandom); in_eob = 1'($urandom);
            tick;
            g++;
         end
         in_valid = 1'b1; in_data = stim[k]; in_eob = eob && (k == n - 1);
         chk("in_ready_fill", 32'(in_ready), 1);
         tick;
      end
      in_valid = 1'b0; in_eob = 1'b0;
   endtask

   // Called right after the final accept edge
   task automatic finish_block(input string tag, input int n, input bit chk_lat);
      model(n);
      chk({tag, "_in_ready_full"}, 32'(in_ready), 0);
      if (chk_lat) chk({tag, "_valid_edge1"}, 32'(out_valid), 0);
      tick;
      chk({tag, "_valid_edge2"}, 32'(out_valid), 1);
      check_out(tag, exp_o, exp_sat);
   endtask

   task automatic ramp_block(input string tag, input int gap_pct);
      for (int k = 0; k < 64; k++) stim[k] = 16'(zz[k]);
      send_block(64, 1'b0, gap_pct);
      finish_block(tag, 64, 1'b1);
      for (int i = 0; i < 64; i++) chk({tag, "_val"}, 32'(o[i]), i);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_eob = 1'b0; in_data = '0; out_ready = 1'b1;
      build_zz;
      repeat (3) tick;
      chk("reset_in_ready", 32'(in_ready), 0);
      chk("reset_out_valid", 32'(out_valid), 0);
      for (int i = 0; i < 64; i++) exp_o[i] = '0;
      check_out("reset_out", exp_o, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", 32'(in_ready), 1);

      ramp_block("ramp", 0);

      for (int k = 0; k < 64; k++) stim[k] = '0;
      stim[0] = -16'sd240; stim[1] = 16'sd8;
      send_block(2, 1'b1, 0);
      finish_block("eob", 2, 1'b1);

      for (int k = 0; k < 64; k++) stim[k] = '0;
      stim[0] = 16'sd3000; stim[2] = -16'sd5000;
      send_block(64, 1'b0, 0);
      finish_block("clamp", 64, 1'b1);
      chk("clamp_out0", 32'(o[0]), 2047);
      chk("clamp_out8", 32'(o[8]), -2048);
      chk("clamp_sat", 32'(sat_flag), 1);

      for (int k = 0; k < 64; k++) stim[k] = 16'(int'($urandom_range(4095)) - 2048);
      send_block(64, 1'b0, 0);
      finish_block("clean", 64, 1'b1);
      chk("clean_sat", 32'(sat_flag), 0);

      repeat (5) begin
         int n = $urandom_range(1, 64);
         for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
         send_block(n, 1'b1, 30);
         finish_block("rand", n, 1'b1);
      end

      for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
      send_block(64, 1'b1, 0);
      finish_block("eob_at_63", 64, 1'b1);

      // Backpressure: A presented, B completes and must wait
      tick;
      out_ready = 1'b0;
      for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
      send_block(64, 1'b0, 0);
      finish_block("bp_a", 64, 1'b1);
      hold_o = exp_o; hold_sat = exp_sat;
      for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
      send_block(64, 1'b0, 0);
      chk("bp_b_in_ready", 32'(in_ready), 0);
      repeat (3) begin
         tick;
         chk("bp_hold_in_ready", 32'(in_ready), 0);
         chk("bp_hold_valid", 32'(out_valid), 1);
         check_out("bp_hold_a", hold_o, hold_sat);
      end
      model(64);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("bp_b_valid", 32'(out_valid), 1);
      chk("bp_b_in_ready", 32'(in_ready), 1);
      check_out("bp_b", exp_o, exp_sat);
      out_ready = 1'b1;
      tick;
      chk("bp_b_drain", 32'(out_valid), 0);

      // Reset with a pending output block and a partial fill
      out_ready = 1'b0;
      for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
      send_block(64, 1'b0, 0);
      finish_block("pre_rst", 64, 1'b1);
      for (int k = 0; k < 64; k++) stim[k] = 16'($urandom);
      send_block(30, 1'b0, 0);
      rst = 1'b1;
      tick;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 0);
      for (int i = 0; i < 64; i++) exp_o[i] = '0;
      check_out("midrst_out", exp_o, 1'b0);
      tick;
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("midrst_release_in_ready", 32'(in_ready), 1);
      ramp_block("ramp_after_rst", 0);

      ramp_block("ramp_gapped", 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/idct_block_loader.md
# idct_block_loader

Upstream feeder for the 64-input IDCT pipeline. It accepts one 16-bit signed coefficient per handshake in JPEG zigzag order and places each one at its raster position. It clamps each coefficient to the IDCT input range and supports end-of-block (EOB) zero-fill. Completed blocks are presented as 64 parallel, stable words on out0..out63 with a valid/ready handshake; for a direct IDCT connection, out_ready is tied high.

## Interface
- WIDTH, 16, coefficient and output word width (signed).
- CLAMP_BITS, 12, signed saturation range: [-2^(CLAMP_BITS-1), 2^(CLAMP_BITS-1)-1].
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  signed coefficient, zigzag order.
- in_valid  input  1  in_data/in_eob valid.
- in_eob  input  1  this coefficient is the last nonzero one; remaining positions become 0.
- in_ready  output  1  loader can accept a coefficient.
- out0 … out63  output  WIDTH each  raster-order block; outN = row N/8, column N%8.
- out_valid  output  1  block on out0..out63 is valid.
- out_ready  input  1  downstream accepts the block.
- sat_flag  output  1  at least one coefficient of the presented block was clamped; qualified by out_valid.

## Operation
- Storage: a fill bank (64×WIDTH plus a sticky sat bit), an output bank (64×WIDTH, out_valid, sat_flag), and a 6-bit index counter idx.
- Zigzag map: the coefficient at stream index k is written to fill[ZZ[k]]. ZZ is the standard JPEG table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,…,55,62,63. It is a 64-entry constant.
- Clamp: values above 2047 become 2047. Values below -2048 become -2048. Results are sign-extended to WIDTH. Any clamp sets the fill-bank sat bit.
- States:
  - FILL: in_ready=1. On accept (in_valid && in_ready), write the clamped coefficient and increment idx. If idx==63 or in_eob=1, go to FULL; otherwise stay in FILL.
  - FULL: in_ready=0. If !out_valid || out_ready, copy the fill bank to the output bank, set out_valid=1 and sat_flag=fill sat, then clear the fill bank (all 0, sat 0), set idx=0, and go to FILL. Otherwise hold.
- EOB: positions after the EOB coefficient remain 0 because the fill bank is cleared on every transfer. in_eob at idx==63 is equivalent to a normal completion.
- Output handshake:
  - out_valid drops on out_valid && out_ready, unless a new transfer happens on the same edge; in that case out_valid stays 1 and the new block is loaded.
  - out0..out63 and sat_flag change only on a transfer and are otherwise stable.
- in_eob is ignored when in_valid=0.

## Timing
- Reset values: state=FILL, idx=0, fill bank all 0, out0..out63 all 0, out_valid=0, sat_flag=0.
- in_ready=0 while rst=1; in_ready=1 in the first cycle after reset deasserts.
- Reset mid-block: the partial block is discarded, and any pending output block is dropped (out_valid=0).
- Latency: with the output bank free, out_valid is seen high 2 rising edges after the edge that accepts the final coefficient. Edge 1 enters FULL; edge 2 performs the transfer.
- Throughput: at most one block per 65 cycles (64 accepts plus one FULL cycle); EOB blocks are shorter.
- Backpressure: with out_ready=0 and out_valid=1, a second completed block waits in FULL with in_ready=0. The transfer occurs on the edge where out_ready=1. Nothing is lost or overwritten.
- Simultaneous events:
  - Downstream acceptance and a FULL→FILL transfer on the same edge: the new block replaces the old one and out_valid stays 1.
  - A combinational path from in_valid to in_ready is forbidden; in_ready depends only on state and rst.

## Test plan
- Ramp: stream zigzag k carries value ZZ[k] for k=0..63, with in_valid held high → out_i == i for all i, sat_flag=0, out_valid high 2 edges after the 64th accept.
- EOB: send -240 at k=0, then 8 at k=1 with in_eob=1 → out0=-240, out1=8, all other outputs 0, out_valid after 2 edges. The next block starts at idx 0 with no leftover values.
- Clamp: send 3000 at k=0, -5000 at k=2, and 0 elsewhere → out0=2047, out8=-2048, sat_flag=1. An immediately following clean block → sat_flag=0.
- Backpressure:
  - Hold out_ready=0 and send two full blocks A then B → A stays on the outputs unchanged, and in_ready=0 after B's 64th accept.
  - Raise out_ready for 1 cycle → B is presented on the next edge and out_valid stays 1.
- Reset mid-block: assert rst after 30 accepts → out_valid=0 and all outputs 0. The next full ramp block yields out_i == i exactly.
- Gapped input: random in_valid idle cycles (at least 50% gaps) on the ramp block → identical outputs. out_valid rises exactly 2 edges after the final accept.
